// File: rtl/vertex_streamer_if.sv
// vertex_streamer_if: valid/ready vertex stream carrying a signed (x,y,z) point plus index and last flag.
interface vertex_streamer_if #(
    parameter int POINT_WIDTH = 12,
    parameter int IDX_WIDTH   = 5
);
    logic signed [POINT_WIDTH-1:0] pt_out [3];
    logic                          valid_out;
    logic                          last_out;
    logic [IDX_WIDTH-1:0]          idx_out;
    logic                          ready_in;
    modport master (output pt_out, valid_out, last_out, idx_out, input ready_in);
    modport slave  (input pt_out, valid_out, last_out, idx_out, output ready_in);
endinterface

// File: rtl/vertex_streamer.sv
// vertex_streamer: streams a fixed 20-entry cube/dodecahedron vertex table per start pulse over valid/ready.
// Optional VERTEX_STREAMER_SCALE_EN adds scale_shift, an arithmetic right shift captured at frame start.
module vertex_streamer #(
    parameter int POINT_WIDTH = 12,
    parameter int NUM_POINTS  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
`ifdef VERTEX_STREAMER_SCALE_EN
    input  logic [1:0]        scale_shift,
`endif
    vertex_streamer_if.master vs,
    output logic              busy,
    output logic              done
);
    localparam int IDX_WIDTH = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POINTS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    // Cube corners use index bits as sign bits (x slowest); dodecahedron entries are
    // (0, +/-1656, +/-632) rotated left by (k mod 3), sign pair selected by k/3.
    function automatic int coord(input int i, input int a);
        int k;
        int v [3];
        if (i < 8) return ((i >> (2 - a)) & 1) != 0 ? 1024 : -1024;
        k    = i - 8;
        v[0] = 0;
        v[1] = k / 3 >= 2 ? 1656 : -1656;
        v[2] = (k / 3) % 2 != 0 ? 632 : -632;
        return v[(a + k % 3) % 3];
    endfunction

    state_t                        state_q, state_d;
    logic signed [POINT_WIDTH-1:0] pt_q [3];
    logic signed [POINT_WIDTH-1:0] pt_d [3];
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [IDX_WIDTH-1:0]          idx_q, idx_d, nxt_idx;
    logic [1:0]                    shift_eff;
    logic                          hs, load;

`ifdef VERTEX_STREAMER_SCALE_EN
    logic [1:0] shift_q, shift_d;
    // Input is followed while idle, so the value present on the accepting edge is what gets held.
    assign shift_eff = state_q == IDLE ? scale_shift : shift_q;
    assign shift_d   = shift_eff;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shift_q <= '0;
        else      shift_q <= shift_d;
    end
`else
    assign shift_eff = 2'd0;
`endif

    always_comb begin
        hs      = valid_q & vs.ready_in;
        load    = state_q == IDLE ? start & ~abort : ~abort & hs & ~last_q;
        nxt_idx = state_q == IDLE ? '0 : idx_q + 1'b1;
        state_d = state_q;
        pt_d    = pt_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = STREAM;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            idx_d   = nxt_idx;
            last_d  = nxt_idx == LAST_IDX;
            for (int a = 0; a < 3; a++)
                pt_d[a] = POINT_WIDTH'(coord(int'(nxt_idx), a) >>> shift_eff);
        end else if (state_q == STREAM && (abort || hs)) begin
            // Abort takes priority over a simultaneous final handshake and suppresses done.
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = ~abort;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pt_q    <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign vs.pt_out    = pt_q;
    assign vs.valid_out = valid_q;
    assign vs.last_out  = last_q;
    assign vs.idx_out   = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_vertex_streamer.sv
// tb_vertex_streamer: table-driven and directed checks of vertex_streamer against hand-written expected vertices.
module tb_vertex_streamer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;
`ifdef VERTEX_STREAMER_SCALE_EN
    logic [1:0] scale_shift = 2'd0;
`endif
    int checks = 0;
    int errors = 0;

    int exp_tbl [20][3] = '{
        '{-1024, -1024, -1024}, '{-1024, -1024, 1024}, '{-1024, 1024, -1024}, '{-1024, 1024, 1024},
        '{1024, -1024, -1024},  '{1024, -1024, 1024},  '{1024, 1024, -1024},  '{1024, 1024, 1024},
        '{0, -1656, -632}, '{-1656, -632, 0}, '{-632, 0, -1656},
        '{0, -1656, 632},  '{-1656, 632, 0},  '{632, 0, -1656},
        '{0, 1656, -632},  '{1656, -632, 0},  '{-632, 0, 1656},
        '{0, 1656, 632},   '{1656, 632, 0},   '{632, 0, 1656}
    };

    typedef struct {
        bit start, abort, ready, ev;
        int idx;
        bit last, busy, done;
    } vec_t;
    vec_t vq [$];

    vertex_streamer_if #(.POINT_WIDTH(12), .IDX_WIDTH(5)) vs ();

    vertex_streamer #(.POINT_WIDTH(12), .NUM_POINTS(20)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
`ifdef VERTEX_STREAMER_SCALE_EN
        .scale_shift(scale_shift),
`endif
        .vs(vs),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_pt(string name, int i, int sh);
        for (int a = 0; a < 3; a++)
            chk($sformatf("%s pt[%0d]", name, a), vs.pt_out[a], exp_tbl[i][a] >>> sh);
    endtask

    function automatic void add(bit s, a, r, v, int i, bit l, b, d);
        vq.push_back('{s, a, r, v, i, l, b, d});
    endfunction

    initial begin
        int n, stall, g;
        vs.ready_in = 1'b0;
        step();
        step();
        chk("rst valid", vs.valid_out, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst last", vs.last_out, 0);
        chk("rst idx", vs.idx_out, 0);
        for (int a = 0; a < 3; a++) chk("rst pt", vs.pt_out[a], 0);
        rst = 1'b1;
        step();

        // full-rate frame, restart in the done cycle, start while busy, abort on the last handshake
        add(1, 0, 1, 1, 0, 0, 1, 0);
        for (int k = 1; k < 20; k++) add(0, 0, 1, 1, k, k == 19, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 1, 0);
        for (int k = 1; k < 20; k++) add(k == 5, 0, 1, 1, k, k == 19, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        foreach (vq[r]) begin
            start       = vq[r].start;
            abort       = vq[r].abort;
            vs.ready_in = vq[r].ready;
            step();
            chk($sformatf("vec%0d valid", r), vs.valid_out, vq[r].ev);
            chk($sformatf("vec%0d busy", r), busy, vq[r].busy);
            chk($sformatf("vec%0d done", r), done, vq[r].done);
            chk($sformatf("vec%0d last", r), vs.last_out, vq[r].last);
            if (vq[r].ev) begin
                chk($sformatf("vec%0d idx", r), vs.idx_out, vq[r].idx);
                chk_pt($sformatf("vec%0d", r), vq[r].idx, 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;

        // backpressure: five stalled cycles while index 3 is presented
        start = 1'b1;
        vs.ready_in = 1'b0;
        step();
        start = 1'b0;
        n = 0;
        stall = 0;
        g = 0;
        while (n < 20 && g < 200) begin
            vs.ready_in = (vs.idx_out == 5'd3 && stall < 5) ? 1'b0 : 1'b1;
            if (!vs.ready_in) stall++;
            chk("t3 valid", vs.valid_out, 1);
            chk("t3 idx", vs.idx_out, n);
            chk("t3 last", vs.last_out, n == 19);
            chk_pt("t3", n, 0);
            if (vs.ready_in) n++;
            step();
            g++;
        end
        chk("t3 handshakes", n, 20);
        chk("t3 stalls", stall, 5);
        chk("t3 done", done, 1);
        step();

        // asynchronous reset mid-frame
        vs.ready_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t1 pre idx", vs.idx_out, 2);
        rst = 1'b0;
        #1;
        chk("t1 valid", vs.valid_out, 0);
        chk("t1 busy", busy, 0);
        chk("t1 idx", vs.idx_out, 0);
        for (int a = 0; a < 3; a++) chk("t1 pt", vs.pt_out[a], 0);
        step();
        rst = 1'b1;
        step();
        chk("t1 idle valid", vs.valid_out, 0);
        chk("t1 idle busy", busy, 0);
        chk("t1 idle done", done, 0);

`ifdef VERTEX_STREAMER_SCALE_EN
        scale_shift = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        scale_shift = 2'd0;
        chk("t6 idx0", vs.idx_out, 0);
        chk_pt("t6 idx0", 0, 2);
        g = 0;
        while (vs.idx_out != 5'd8 && g < 20) begin
            step();
            g++;
        end
        chk("t6 idx8", vs.idx_out, 8);
        chk_pt("t6 idx8", 8, 2);
        g = 0;
        while (!done && g < 40) begin
            step();
            g++;
        end
        chk("t6 done", done, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
